// File: rtl/row_sequencer.sv
// Word-line row sequencer: drives one registered one-hot row select for single
// accesses or inclusive (optionally wrapping) sweeps, with a break-before-make gap.
module row_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int NUM_ROWS = 32,
  parameter int PULSE_W  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  input  logic                scan_start,
  input  logic [ADDR_W-1:0]   scan_first,
  input  logic [ADDR_W-1:0]   scan_last,
  input  logic                scan_abort,
  output logic [NUM_ROWS-1:0] row_sel,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

  localparam logic [ADDR_W:0]   ROWS_W     = (ADDR_W+1)'(NUM_ROWS);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(NUM_ROWS - 1);
  localparam logic [3:0]        PULSE_LAST = 4'(PULSE_W - 1);

  state_e                state_q;
  logic [ADDR_W-1:0]     row_q, last_q;
  logic [3:0]            pulse_q;
  logic                  scan_q, final_q;
  logic [NUM_ROWS-1:0]   row_sel_q;
  logic                  ready_q, busy_q, done_q, aborted_q, err_q;

  logic [ADDR_W-1:0]     start_row_d, next_row_d;
  logic                  start_ok_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < ROWS_W;
  endfunction

  function automatic logic [NUM_ROWS-1:0] onehot(input logic [ADDR_W-1:0] a);
    return NUM_ROWS'(1) << a;
  endfunction

  // A scan wins over a simultaneous single request; the request is simply dropped.
  always_comb begin
    start_row_d = req_addr;
    start_ok_d  = in_range(req_addr);
    if (scan_start) begin
      start_row_d = scan_first;
      start_ok_d  = in_range(scan_first) && in_range(scan_last);
    end
  end

  // Wrap at NUM_ROWS rather than at the natural 2**ADDR_W boundary.
  assign next_row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; the pulse defaults below rely on later assignments winning.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      last_q    <= '0;
      pulse_q   <= '0;
      scan_q    <= 1'b0;
      final_q   <= 1'b0;
      row_sel_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (scan_start || req_valid) begin
            if (start_ok_d) begin
              state_q   <= ACTIVE;
              row_q     <= start_row_d;
              row_sel_q <= onehot(start_row_d);
              pulse_q   <= PULSE_LAST;
              scan_q    <= scan_start;
              if (scan_start) last_q <= scan_last;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (scan_q && scan_abort) begin
            state_q   <= GAP;
            row_sel_q <= '0;
            final_q   <= 1'b1;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (pulse_q == '0) begin
            state_q   <= GAP;
            row_sel_q <= '0;
            final_q   <= !scan_q || (row_q == last_q);
            done_q    <= !scan_q || (row_q == last_q);
          end else begin
            pulse_q <= pulse_q - 1'b1;
          end
        end
        GAP: begin
          if (final_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (scan_abort) begin
            // Abort landing in an intermediate gap: spend one more gap to report it.
            final_q   <= 1'b1;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            state_q   <= ACTIVE;
            row_q     <= next_row_d;
            row_sel_q <= onehot(next_row_d);
            pulse_q   <= PULSE_LAST;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign row_sel   = row_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_row_sequencer.sv
// Directed bench for row_sequencer: a 32-row instance for most behaviour and a
// 24-row instance sharing the same stimulus for the out-of-range rejection cases.
module tb_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, scan_start, scan_abort;
  logic [4:0]  req_addr, scan_first, scan_last;

  logic        req_ready, busy, done, aborted, err;
  logic [31:0] row_sel;
  logic        req_ready_24, busy_24, done_24, aborted_24, err_24;
  logic [23:0] row_sel_24;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  row_sequencer #(.ADDR_W(5), .NUM_ROWS(32), .PULSE_W(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .scan_start(scan_start), .scan_first(scan_first),
    .scan_last(scan_last), .scan_abort(scan_abort), .row_sel(row_sel),
    .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  row_sequencer #(.ADDR_W(5), .NUM_ROWS(24), .PULSE_W(2)) u_dut_24 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_24), .scan_start(scan_start), .scan_first(scan_first),
    .scan_last(scan_last), .scan_abort(scan_abort), .row_sel(row_sel_24),
    .busy(busy_24), .done(done_24), .aborted(aborted_24), .err(err_24)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (req_ready && req_ready_24) break;
      step();
    end
    check({tag, "_idle"}, 64'(req_ready && req_ready_24), 64'd1);
  endtask

  // Single access on the 32-row instance: two active cycles, one gap with done, then idle.
  task automatic single(input int a, input logic abort_held);
    logic [31:0] exp_row;
    exp_row = 32'd1 << a;
    check($sformatf("ready_before_%0d", a), 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = 5'(a);
    step();
    req_valid = 1'b0;
    check($sformatf("row_c1_%0d", a), 64'(row_sel), 64'(exp_row));
    check($sformatf("busy_c1_%0d", a), 64'(busy), 64'd1);
    step();
    check($sformatf("row_c2_%0d", a), 64'(row_sel), 64'(exp_row));
    step();
    check($sformatf("gap_%0d", a), {31'd0, done, aborted, row_sel}, {31'd0, 1'b1, 1'b0, 32'd0});
    step();
    check($sformatf("idle_%0d", a), {61'd0, req_ready, busy, done}, {61'd0, 3'b100});
    if (abort_held) check("abort_ignored_single", 64'(aborted), 64'd0);
  endtask

  initial begin
    int rows[4];
    rows = '{30, 31, 0, 1};

    rst = 1'b1; req_valid = 1'b0; scan_start = 1'b0; scan_abort = 1'b0;
    req_addr = '0; scan_first = '0; scan_last = '0;
    step(); step();
    check("rst_outputs", {59'd0, busy, done, aborted, err, |row_sel}, 64'd0);
    rst = 1'b0;
    step();
    check("rst_ready", 64'(req_ready), 64'd1);

    // Single access at row 7 against the literal one-hot value, then every address.
    req_valid = 1'b1; req_addr = 5'd7;
    step();
    req_valid = 1'b0;
    check("row7_literal", 64'(row_sel), 64'h0000_0080);
    wait_idle("row7");
    for (int a = 0; a < 32; a++) single(a, 1'b0);

    // Wrapping scan 30 -> 1: rows 30,31,0,1, each two cycles plus a gap; 12 cycles.
    scan_start = 1'b1; scan_first = 5'd30; scan_last = 5'd1;
    step();
    scan_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("wrap_row_k%0d", k), 64'(row_sel),
            (k % 3 == 2) ? 64'd0 : 64'(32'd1 << rows[k/3]));
      check($sformatf("wrap_done_k%0d", k), 64'(done), 64'(k == 11));
      step();
    end
    check("wrap_end", {62'd0, req_ready, busy}, 64'b10);

    // Abort held in idle is ignored, and also during a single access.
    scan_abort = 1'b1;
    step();
    check("abort_idle", {61'd0, req_ready, done, aborted}, 64'b100);
    single(2, 1'b1);
    scan_abort = 1'b0;

    // Scan 3..10 aborted while row 5 is active.
    scan_start = 1'b1; scan_first = 5'd3; scan_last = 5'd10;
    step();
    scan_start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("abort_row5", 64'(row_sel), 64'h0000_0020);
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
    check("abort_gap", {29'd0, busy, done, aborted, row_sel}, {29'd0, 3'b111, 32'd0});
    step();
    check("abort_idle_after", {61'd0, req_ready, busy, aborted}, 64'b100);

    // Scan and request together: scan of row 4 wins, row 9 never appears.
    scan_start = 1'b1; scan_first = 5'd4; scan_last = 5'd4;
    req_valid = 1'b1; req_addr = 5'd9;
    step();
    scan_start = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("both_row_k%0d", k), 64'(row_sel), (k < 2) ? 64'h10 : 64'd0);
      check($sformatf("both_done_k%0d", k), 64'(done), 64'(k == 2));
      step();
    end
    check("both_idle", 64'(req_ready), 64'd1);

    // 24-row instance: row 23 is legal, 24 and a scan bound of 25 are rejected.
    req_valid = 1'b1; req_addr = 5'd23;
    step();
    req_valid = 1'b0;
    check("r24_row23", {31'd0, err_24, 8'd0, row_sel_24}, {31'd0, 1'b0, 8'd0, 24'h80_0000});
    wait_idle("r24_row23");
    req_valid = 1'b1; req_addr = 5'd24;
    step();
    req_valid = 1'b0;
    check("r24_addr24_err", {61'd0, err_24, busy_24, req_ready_24}, 64'b101);
    check("r24_addr24_row", 64'(row_sel_24), 64'd0);
    check("r32_addr24_row", 64'(row_sel), 64'(32'd1 << 24));
    step();
    check("r24_addr24_pulse", {62'd0, err_24, done_24}, 64'd0);
    wait_idle("r24_addr24");
    scan_start = 1'b1; scan_first = 5'd2; scan_last = 5'd25;
    step();
    scan_start = 1'b0;
    check("r24_last25_err", {61'd0, err_24, busy_24, |row_sel_24}, 64'b100);
    check("r32_last25_ok", {62'd0, err, busy}, 64'b01);
    step();
    check("r24_last25_pulse", 64'(err_24), 64'd0);
    wait_idle("r32_sweep");

    // Reset in the middle of scan 6..12 while row 8 is driven.
    scan_start = 1'b1; scan_first = 5'd6; scan_last = 5'd12;
    step();
    scan_start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("rst_mid_row8", 64'(row_sel), 64'h0000_0100);
    rst = 1'b1;
    step();
    check("rst_mid_outputs", {59'd0, busy, done, aborted, err, |row_sel}, 64'd0);
    rst = 1'b0;
    step();
    check("rst_mid_after", {61'd0, req_ready, done, |row_sel}, 64'b100);
    single(7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/row_sequencer.md
ROW_SEQUENCER -- requirements
Module: row_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5: row address width.
REQ-002 Parameter NUM_ROWS, default 32: rows driven; legal range 2..2**ADDR_W.
REQ-003 Parameter PULSE_W, default 1: word-line active cycles per row; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  single-row access request.
REQ-007 req_addr  input  ADDR_W  row address for single access.
REQ-008 req_ready  output  1  block accepts req_valid or scan_start this cycle.
REQ-009 scan_start  input  1  start sweep from scan_first to scan_last.
REQ-010 scan_first, scan_last  input  ADDR_W each  sweep bounds, inclusive.
REQ-011 scan_abort  input  1  terminate sweep in progress.
REQ-012 row_sel  output  NUM_ROWS  registered one-hot word-line select; all-zero when idle.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at operation completion.
REQ-015 aborted  output  1  one-cycle pulse, coincident with done, when a sweep ends by scan_abort.
REQ-016 err  output  1  one-cycle pulse on rejected out-of-range address.

Function
REQ-017 FSM states IDLE, ACTIVE, GAP; all outputs registered.
REQ-018 req_ready = 1 only in IDLE; accept = (scan_start or req_valid) and req_ready.
REQ-019 scan_start and req_valid together in IDLE: scan accepted, request dropped (requester re-issues).
REQ-020 Single access, req_addr < NUM_ROWS: next cycle ACTIVE, row_sel = one-hot(req_addr) for exactly PULSE_W cycles.
REQ-021 After every ACTIVE pulse, one GAP cycle with row_sel = 0 (break-before-make); never two rows high in one cycle.
REQ-022 Single access: done pulses during the GAP cycle; IDLE (req_ready = 1) the following cycle.
REQ-023 Any address >= NUM_ROWS (req_addr, scan_first or scan_last): err pulses the cycle after acceptance, row_sel stays 0, FSM stays IDLE, no done.
REQ-024 Scan: rows visited scan_first, scan_first+1, ..., scan_last, each as ACTIVE(PULSE_W) then GAP; bounds latched at acceptance.
REQ-025 scan_last < scan_first: sweep wraps, NUM_ROWS-1 followed by 0, continuing to scan_last.
REQ-026 scan_first = scan_last: exactly one row pulsed.
REQ-027 Scan done pulses during the GAP following scan_last only; no done in intermediate GAPs.
REQ-028 Row counter arithmetic modulo NUM_ROWS, not 2**ADDR_W.
REQ-029 scan_abort while busy in scan: row_sel = 0 the next cycle, one GAP cycle with done and aborted, then IDLE.
REQ-030 scan_abort in IDLE or during a single access: ignored.
REQ-031 Inputs other than scan_abort ignored while busy.

Reset
REQ-032 rst high at a rising edge: FSM = IDLE, row_sel = 0, busy = 0, done = 0, aborted = 0, err = 0, row counter and latched bounds = 0; req_ready = 1 the cycle after rst falls.
REQ-033 rst overrides all inputs, mid-pulse included: row_sel = 0 the cycle after the rst edge, no done pulse.

Verification (ADDR_W=5, NUM_ROWS=32, PULSE_W=2 unless noted)
REQ-034 Single access req_addr=7 -> row_sel=0x00000080 for cycles 1-2 after accept, 0 in cycle 3 with done=1, req_ready=1 in cycle 4; repeat for all addresses 0..31.
REQ-035 Scan first=30, last=1 -> rows 30,31,0,1 each 2 cycles separated by one zero cycle; done only after row 1; total 12 cycles.
REQ-036 NUM_ROWS=24, req_addr=24 -> err=1 one cycle, row_sel=0, busy=0; scan_last=25 -> err likewise.
REQ-037 scan_abort while row 5 is active in scan 3..10 -> row_sel=0 next cycle with done=1 and aborted=1, IDLE after.
REQ-038 scan_start and req_valid together (first=last=4, req_addr=9) -> only row 4 pulsed, row 9 never asserted.
REQ-039 rst asserted mid-scan while row_sel=0x00000100 -> all outputs 0 next cycle, no done; new request after rst behaves per REQ-034.
